persp_div_q12: RTL
==================

Name: persp_div_q12

Overview:
- Perspective-projection stage directly downstream of the 3x3 Q12 transform.
- Accepts one transformed point (x, y, z, signed Q12) per handshake.
- Computes q = FOCAL/z with a bit-serial restoring divider, then screen coordinates sx = x*q + CX and sy = y*q + CY, rounded and saturated.
- Points closer than ZNEAR are flagged as clipped. One transaction is in flight at a time.

Parameters:
- W, 24, data width of all coordinate ports (signed, two's complement).
- FRAC, 12, fractional bits (Q12).
- FOCAL, 4096, focal length in Q12; must be positive (default 1.0).
- ZNEAR, 256, near-plane threshold in Q12; must be positive (default 0.0625).
- CX, 0, screen-centre x offset in Q12.
- CY, 0, screen-centre y offset in Q12.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream point valid.
- in_ready  out  1  block can accept a point.
- x_in  in  W  signed Q12 x from the transform stage.
- y_in  in  W  signed Q12 y from the transform stage.
- z_in  in  W  signed Q12 z (depth) from the transform stage.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sx  out  W  signed Q12 screen x.
- sy  out  W  signed Q12 screen y.
- zq  out  W  registered copy of z_in, for the depth buffer.
- clip  out  1  z_in < ZNEAR; sx and sy are forced to 0.

Behaviour:
- Reset (asynchronous, active-high):
  - state goes to IDLE; out_valid, clip, sx, sy and zq go to 0; divider registers are cleared.
  - in_ready = (state==IDLE) && !rst, so it is 0 while rst is high.
  - Reset mid-operation aborts the transaction; nothing is emitted.
- States: IDLE, DIV, MUL, DONE.
- IDLE:
  - in_ready=1. An accept occurs on an edge with in_valid && in_ready.
  - On accept, x, y and z are captured into internal registers and zq <= z_in.
  - If signed z_in < ZNEAR: clip<=1, sx<=0, sy<=0, out_valid<=1, go to DONE. Result is valid 1 edge after the accepting edge.
  - Otherwise: load the divider with numerator N = FOCAL<<FRAC (unsigned, W+FRAC bits) and divisor D = z_in (positive), then go to DIV.
- DIV:
  - Restoring division, one quotient bit per edge, MSB first, for W+FRAC edges (36 by default).
  - Go to MUL after the final bit.
  - Quotient Q = floor(N/D), truncated. If Q > 2^(W-1)-1, saturate q to 2^(W-1)-1.
- MUL (1 edge):
  - Products are full precision, 2W bits, signed.
  - sx <= sat_W(((x*q + 2^(FRAC-1)) >>> FRAC) + CX); sy is computed the same way with y and CY.
  - sat_W clamps to [-2^(W-1), 2^(W-1)-1]. The offset is added before the clamp, with no intermediate wrap.
  - clip<=0, out_valid<=1, go to DONE.
  - Unclipped latency: out_valid rises W+FRAC+1 edges after the accepting edge (37 by default).
- DONE:
  - sx, sy, zq and clip are held stable while out_valid && !out_ready.
  - When out_valid && out_ready at an edge: out_valid<=0, go to IDLE.
  - in_ready is 0 in DONE; no same-cycle reaccept, so throughput is at most 1 point per W+FRAC+3 cycles.
- in_valid while busy is ignored; upstream holds it.
- x_in, y_in and z_in are sampled only on the accepting edge and may change afterwards.
- z_in == ZNEAR exactly is not clipped.

Decomposition:
- Shared package holds:
  - W/FRAC defaults;
  - the state enum {IDLE, DIV, MUL, DONE};
  - the sat_W function (clamp 2W-bit signed to W bits);
  - the Q12 rounding constant 2^(FRAC-1).
- Sub-module udiv_serial (parameter NBITS = W+FRAC):
  - ports: start, numerator, divisor, busy, done, quotient.
  - Contains the shift/subtract iteration.
  - persp_div_q12 keeps the FSM, the multiply and the saturation.

Test Plan:
- Basic (defaults): x=8192 (2.0), y=-4096, z=8192 → q=2048; sx=4096, sy=-2048, zq=8192, clip=0; out_valid exactly 37 edges after accept.
- Rounding/truncation: x=12288, y=0, z=12288 → q=1365; sx=4095 (not 4096), sy=0.
- Saturation: z=256 (=ZNEAR, not clipped), x=600000, y=-600000 → q=65536; sx=8388607, sy=-8388608, clip=0.
- Clip: z=0 and, separately, z=-4096 → clip=1, sx=sy=0, zq=z_in; out_valid 1 edge after accept.
- Backpressure: out_ready=0 for 10 cycles after out_valid → outputs constant and in_ready=0. A second in_valid is not accepted until the edge after out_ready=1, and is then processed correctly.
- Reset mid-DIV: rst asserted 10 edges after accept → out_valid=0, sx=sy=zq=0 immediately (asynchronous) and in_ready=0 during rst. After release, the next point (the basic case) produces the correct result with 37-edge latency.

Source files
------------

// File: rtl/persp_div_q12_pkg.sv
// ============================================================================
// persp_div_q12_pkg : shared types and helpers for the perspective divider
// rev 1.0
// ============================================================================
`default_nettype none

package persp_div_q12_pkg;

   localparam int W_DEF    = 24;
   localparam int FRAC_DEF = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Half an LSB of the fractional part, added before the Q-format shift.
   function automatic logic signed [63:0] round_const(input int frac);
      return 64'sd1 <<< (frac - 1);
   endfunction

   // Clamp a wide signed value into the signed range of a w-bit word.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] v,
                                                input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (w - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/persp_div_q12_udiv.sv
// ============================================================================
// udiv_serial : restoring unsigned divider, one quotient bit per clock, MSB first
// rev 1.0
// ============================================================================
`default_nettype none

module udiv_serial
   import persp_div_q12_pkg::*;
#(
   parameter int NBITS = W_DEF + FRAC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NBITS-1:0] numerator,
   input  logic [NBITS-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [NBITS-1:0] quotient
);

   localparam int c_CW = $clog2(NBITS + 1);

   logic [NBITS-1:0] r_rem;
   logic [NBITS-1:0] r_num;
   logic [NBITS-1:0] r_div;
   logic [NBITS-1:0] r_quo;
   logic [c_CW-1:0]  r_cnt;
   logic             r_busy;

   logic [NBITS:0]   w_rem_sh;
   logic             w_ge;

   assign w_rem_sh = {r_rem, r_num[NBITS-1]};
   assign w_ge     = (w_rem_sh >= {1'b0, r_div});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_num  <= '0;
         r_div  <= '0;
         r_quo  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start) begin
         r_rem  <= '0;
         r_num  <= numerator;
         r_div  <= divisor;
         r_quo  <= '0;
         r_cnt  <= c_CW'(NBITS);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         // Remainder always stays below the divisor, so NBITS bits suffice.
         r_rem  <= w_ge ? NBITS'(w_rem_sh - {1'b0, r_div}) : w_rem_sh[NBITS-1:0];
         r_num  <= r_num << 1;
         r_quo  <= {r_quo[NBITS-2:0], w_ge};
         r_cnt  <= r_cnt - c_CW'(1);
         if (r_cnt == c_CW'(1)) r_busy <= 1'b0;
      end
   end

   // High during the cycle whose closing edge writes the last quotient bit.
   assign done     = r_busy && (r_cnt == c_CW'(1));
   assign busy     = r_busy;
   assign quotient = r_quo;

endmodule

`default_nettype wire

// File: rtl/persp_div_q12.sv
// ============================================================================
// persp_div_q12 : perspective projection sx = x*FOCAL/z + CX, sy likewise, Q12
// rev 1.0
// ============================================================================
`default_nettype none

module persp_div_q12
   import persp_div_q12_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int FRAC  = FRAC_DEF,
   parameter int FOCAL = 4096,
   parameter int ZNEAR = 256,
   parameter int CX    = 0,
   parameter int CY    = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] x_in,
   input  logic signed [W-1:0] y_in,
   input  logic signed [W-1:0] z_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] sx,
   output logic signed [W-1:0] sy,
   output logic signed [W-1:0] zq,
   output logic                clip
);

   localparam int c_NB = W + FRAC;
   localparam int c_PW = 2 * W + 2;

   localparam logic [c_NB-1:0]        c_NUM   = c_NB'(FOCAL) << FRAC;
   localparam logic [c_NB-1:0]        c_QMAX  = c_NB'(2 ** (W - 1) - 1);
   localparam logic signed [W-1:0]    c_ZNEAR = W'(ZNEAR);
   localparam logic signed [c_PW-1:0] c_RND   = c_PW'(round_const(FRAC));
   localparam logic signed [c_PW-1:0] c_CX    = c_PW'(CX);
   localparam logic signed [c_PW-1:0] c_CY    = c_PW'(CY);

   state_t              r_state;
   logic signed [W-1:0] r_x;
   logic signed [W-1:0] r_y;

   logic                w_clip;
   logic                w_start;
   logic                w_div_busy;
   logic                w_div_done;
   logic [c_NB-1:0]     w_quo;
   logic signed [W-1:0] w_q;
   logic signed [c_PW-1:0] w_sx_full;
   logic signed [c_PW-1:0] w_sy_full;

   assign in_ready = (r_state == IDLE) && !rst;
   assign w_clip   = (z_in < c_ZNEAR);
   assign w_start  = (r_state == IDLE) && in_valid && !w_clip;

   udiv_serial #(.NBITS(c_NB)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (w_start),
      .numerator (c_NUM),
      .divisor   ({{FRAC{1'b0}}, z_in}),
      .busy      (w_div_busy),
      .done      (w_div_done),
      .quotient  (w_quo)
   );

   assign w_q = (w_quo > c_QMAX) ? W'(c_QMAX) : w_quo[W-1:0];

   // Computed wide enough that neither rounding nor the offset can wrap.
   assign w_sx_full = ((c_PW'(r_x) * c_PW'(w_q) + c_RND) >>> FRAC) + c_CX;
   assign w_sy_full = ((c_PW'(r_y) * c_PW'(w_q) + c_RND) >>> FRAC) + c_CY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_y       <= '0;
         out_valid <= 1'b0;
         clip      <= 1'b0;
         sx        <= '0;
         sy        <= '0;
         zq        <= '0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_x <= x_in;
               r_y <= y_in;
               zq  <= z_in;
               if (w_clip) begin
                  clip      <= 1'b1;
                  sx        <= '0;
                  sy        <= '0;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_state   <= DIV;
               end
            end
            DIV: if (w_div_done || !w_div_busy) r_state <= MUL;
            MUL: begin
               sx        <= W'(sat_w(64'(w_sx_full), W));
               sy        <= W'(sat_w(64'(w_sy_full), W));
               clip      <= 1'b0;
               out_valid <= 1'b1;
               r_state   <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
